// File: rtl/spi_pkg.sv
// Shared types for the SPI shift engine: FSM state encoding and the SPI mode pair.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_tick_gen.sv
// Loadable half-period counter: counts 0..div and pulses tick on the wrap while running.
module spi_tick_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_l;

  assign tick = run && (cnt == div_l);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load || tick || !run) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Divider is pure data; it is only meaningful once a transfer has been loaded.
  always_ff @(posedge clk) begin
    if (load) begin
      div_l <= div;
    end
  end

endmodule

// File: rtl/spi_engine.sv
// SPI master shift engine: one DATA_W-bit MSB-first transfer per accepted start,
// runtime divider, all four SPI modes, multiple active-low chip selects with hold.
module spi_engine
  import spi_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_CS   = 1,
  parameter int DIV_W    = 8,
  parameter int CS_IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DATA_W-1:0]   tx_data,
  input  logic [CS_IDX_W-1:0] cs_sel,
  input  logic                cs_hold,
  input  logic                cs_release,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIV_W-1:0]    div,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   rx_data,
  output logic                spi_clk,
  output logic                MOSI,
  input  logic                MISO,
  output logic [NUM_CS-1:0]   CS
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE  = EW'(2 * DATA_W);
  localparam logic [EW-1:0] FIRST_EDGE = EW'(1);

  spi_state_t        state;
  spi_mode_t         mode;
  logic              hold_l;
  logic              cs_held;
  logic [EW-1:0]     edge_cnt;
  logic [DATA_W-2:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              tick;

  logic          accept;
  logic          shift_tick;
  logic [EW-1:0] edge_nxt;
  logic          leading;
  logic          sample;
  logic          advance;

  function automatic logic [NUM_CS-1:0] cs_mask(input logic [CS_IDX_W-1:0] sel);
    logic [NUM_CS-1:0] m;
    m = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) m[i] = 1'b0;
    end
    return m;
  endfunction

  assign accept     = (state == IDLE) && start;
  assign shift_tick = (state == SHIFT) && tick;
  assign edge_nxt   = edge_cnt + 1'b1;
  // Odd edges move SCLK away from its idle level.
  assign leading    = edge_nxt[0];
  assign sample     = leading ^ mode.cpha;
  assign advance    = mode.cpha ? (leading && (edge_nxt != FIRST_EDGE))
                                : (!leading && (edge_nxt != LAST_EDGE));

  spi_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick (
    .clk (sys_clk),
    .rst (rst),
    .load(accept),
    .run (state != IDLE),
    .div (div),
    .tick(tick)
  );

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      spi_clk  <= 1'b0;
      MOSI     <= 1'b1;
      CS       <= '1;
      cs_held  <= 1'b0;
      edge_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          spi_clk <= cpol;
          if (!cs_held) MOSI <= 1'b1;
          if (start) begin
            MOSI     <= tx_data[DATA_W-1];
            CS       <= cs_mask(cs_sel);
            cs_held  <= 1'b0;
            edge_cnt <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end else if (cs_release) begin
            cs_held <= 1'b0;
            CS      <= '1;
            MOSI    <= 1'b1;
          end
        end
        SHIFT: begin
          if (tick) begin
            spi_clk  <= ~spi_clk;
            edge_cnt <= edge_nxt;
            if (advance) MOSI <= tx_sr[DATA_W-2];
            if (edge_nxt == LAST_EDGE) state <= HOLD;
          end
        end
        HOLD: begin
          spi_clk <= mode.cpol;
          // CS stays low for one more half-period before the word is handed back.
          if (tick) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            rx_data <= rx_sr;
            cs_held <= hold_l;
            state   <= IDLE;
            if (!hold_l) begin
              CS   <= '1;
              MOSI <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (accept) begin
      mode.cpol <= cpol;
      mode.cpha <= cpha;
      hold_l    <= cs_hold;
      tx_sr     <= tx_data[DATA_W-2:0];
    end else if (shift_tick && advance) begin
      tx_sr <= tx_sr << 1;
    end
    if (shift_tick && sample) begin
      rx_sr <= {rx_sr[DATA_W-2:0], MISO};
    end
  end

endmodule
